// File: rtl/alu_result_stage_pkg.sv
// rtl/alu_result_stage_pkg.sv - shared datapath constants and result entry type
package alu_result_stage_pkg;

   localparam int DATA_W = 40;
   localparam int REG_W  = 5;

   localparam int FLAG_Z = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_N = 0;

   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic [3:0]        flags;
      logic              setFlags;
      logic              writeEn;
      logic [REG_W-1:0]  destReg;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

   function automatic logic [3:0] pack_flags(input logic z, input logic c,
                                             input logic v, input logic n);
      logic [3:0] f;
      f         = '0;
      f[FLAG_Z] = z;
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      f[FLAG_N] = n;
      return f;
   endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// rtl/alu_result_stage_if.sv - alu-to-writeback handshake bundle of the result stage
interface alu_result_stage_if
   import alu_result_stage_pkg::*;
   ;

   logic              controlInValid;
   logic              controlOutReady;
   logic [DATA_W-1:0] dataInResult;
   logic              controlInAluZ;
   logic              controlInAluC;
   logic              controlInAluV;
   logic              controlInAluN;
   logic              controlInSetFlags;
   logic              controlInWriteEn;
   logic [REG_W-1:0]  controlInDestReg;

   logic              controlOutValid;
   logic              controlInReady;
   logic [DATA_W-1:0] dataOutResult;
   logic              controlOutWriteEn;
   logic [REG_W-1:0]  controlOutDestReg;

   modport slave (
      input  controlInValid, dataInResult,
      input  controlInAluZ, controlInAluC, controlInAluV, controlInAluN,
      input  controlInSetFlags, controlInWriteEn, controlInDestReg,
      output controlOutReady,
      output controlOutValid, dataOutResult, controlOutWriteEn, controlOutDestReg,
      input  controlInReady
   );

   modport master (
      output controlInValid, dataInResult,
      output controlInAluZ, controlInAluC, controlInAluV, controlInAluN,
      output controlInSetFlags, controlInWriteEn, controlInDestReg,
      input  controlOutReady,
      input  controlOutValid, dataOutResult, controlOutWriteEn, controlOutDestReg,
      output controlInReady
   );

endinterface

// File: rtl/alu_result_stage_result_fifo.sv
// rtl/alu_result_stage_result_fifo.sv - in-order FIFO with flush and an age-ordered view of all entries
module alu_result_stage_result_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        i_push_valid,
   input  logic [WIDTH-1:0]            i_push_data,
   output logic                        o_push_ready,
   output logic                        o_pop_valid,
   input  logic                        i_pop_ready,
   output logic [WIDTH-1:0]            o_head_data,
   input  logic                        i_flush,
   output logic [DEPTH-1:0][WIDTH-1:0] o_age_data,
   output logic [DEPTH-1:0]            o_age_valid
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;

   logic w_push;
   logic w_pop;

   assign o_push_ready = (r_count < CNT_W'(DEPTH));
   assign o_pop_valid  = (r_count != '0);
   assign o_head_data  = r_mem[r_head];

   // A flushed cycle never stores the incoming entry; the pop is absorbed by head<=tail.
   assign w_push = i_push_valid && o_push_ready && !i_flush;
   assign w_pop  = o_pop_valid && i_pop_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_flush) begin
         r_head  <= r_tail;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_tail] <= i_push_data;
            r_tail        <= r_tail + PTR_W'(1);
         end
         if (w_pop) begin
            r_head <= r_head + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   // Index 0 is the oldest entry, index DEPTH-1 the youngest slot.
   always_comb begin
      o_age_data  = '0;
      o_age_valid = '0;
      for (int k = 0; k < DEPTH; k++) begin
         o_age_data[k]  = r_mem[r_head + PTR_W'(k)];
         o_age_valid[k] = (CNT_W'(k) < r_count);
      end
   end

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - buffers alu results toward writeback, owns status flags, forwards pending results
module alu_result_stage
   import alu_result_stage_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   alu_result_stage_if.slave bus,
   input  logic              controlInFlush,
   output logic              controlOutFlagZ,
   output logic              controlOutFlagC,
   output logic              controlOutFlagV,
   output logic              controlOutFlagN,
   input  logic [REG_W-1:0]  controlInFwdReg,
   output logic              controlOutFwdHit,
   output logic [DATA_W-1:0] dataOutFwd
);

   entry_t                          w_push_entry;
   entry_t                          w_head;
   logic [ENTRY_W-1:0]              w_head_data;
   logic [DEPTH-1:0][ENTRY_W-1:0]   w_age_data;
   logic [DEPTH-1:0]                w_age_valid;
   logic                            w_pop;
   logic [3:0]                      r_flags;

   always_comb begin
      w_push_entry          = '0;
      w_push_entry.result   = bus.dataInResult;
      w_push_entry.flags    = pack_flags(bus.controlInAluZ, bus.controlInAluC,
                                         bus.controlInAluV, bus.controlInAluN);
      w_push_entry.setFlags = bus.controlInSetFlags;
      w_push_entry.writeEn  = bus.controlInWriteEn;
      w_push_entry.destReg  = bus.controlInDestReg;
   end

   alu_result_stage_result_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_push_valid (bus.controlInValid),
      .i_push_data  (w_push_entry),
      .o_push_ready (bus.controlOutReady),
      .o_pop_valid  (bus.controlOutValid),
      .i_pop_ready  (bus.controlInReady),
      .o_head_data  (w_head_data),
      .i_flush      (controlInFlush),
      .o_age_data   (w_age_data),
      .o_age_valid  (w_age_valid)
   );

   assign w_head                = entry_t'(w_head_data);
   assign bus.dataOutResult     = w_head.result;
   assign bus.controlOutWriteEn = w_head.writeEn;
   assign bus.controlOutDestReg = w_head.destReg;

   // The retiring entry is older than any flush cause, so it commits even on a flush cycle.
   assign w_pop = bus.controlOutValid && bus.controlInReady;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_flags <= '0;
      end else if (w_pop && w_head.setFlags) begin
         r_flags <= w_head.flags;
      end
   end

   assign controlOutFlagZ = r_flags[FLAG_Z];
   assign controlOutFlagC = r_flags[FLAG_C];
   assign controlOutFlagV = r_flags[FLAG_V];
   assign controlOutFlagN = r_flags[FLAG_N];

   // Scan oldest to youngest so the youngest matching entry overrides.
   always_comb begin
      entry_t v_entry;
      v_entry          = '0;
      controlOutFwdHit = 1'b0;
      dataOutFwd       = '0;
      for (int k = 0; k < DEPTH; k++) begin
         v_entry = entry_t'(w_age_data[k]);
         if (w_age_valid[k] && v_entry.writeEn && (v_entry.destReg == controlInFwdReg)) begin
            controlOutFwdHit = 1'b1;
            dataOutFwd       = v_entry.result;
         end
      end
   end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Pipeline stage directly downstream of the alu.
- Captures each ALU result and its Z/C/V/N flags into a small in-order buffer with a valid/ready handshake toward writeback.
- Owns the architectural status-flag register; flags update only when an entry retires.
- Provides a forwarding lookup so the upstream operand mux can bypass results that have not yet retired.

Parameters:
- DATA_W, 40, result width; matches the alu datapath.
- REG_W, 5, destination register index width.
- DEPTH, 2, buffer entries; legal values 2 or 4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- controlInValid  in  1  upstream offers an entry this cycle.
- controlOutReady  out  1  stage can accept an entry.
- dataInResult  in  DATA_W  alu result (dataOutALU).
- controlInAluZ/C/V/N  in  1 each  alu flags for this result.
- controlInSetFlags  in  1  this entry updates the flag register when it retires.
- controlInWriteEn  in  1  this entry writes a register.
- controlInDestReg  in  REG_W  destination register index.
- controlInFlush  in  1  discard all non-retiring entries.
- controlOutValid  out  1  head entry available to writeback.
- controlInReady  in  1  writeback accepts the head entry.
- dataOutResult  out  DATA_W  head result.
- controlOutWriteEn  out  1  head write enable.
- controlOutDestReg  out  REG_W  head destination.
- controlOutFlagZ/C/V/N  out  1 each  architectural flags.
- controlInFwdReg  in  REG_W  register index being looked up.
- controlOutFwdHit  out  1  a buffered entry will write controlInFwdReg.
- dataOutFwd  out  DATA_W  forwarded data; 0 when there is no hit.

Behaviour:
- Reset (async, rst_n=0):
  - buffer empty; controlOutValid=0; controlOutReady=1;
  - all four flags 0; head data, destination and write-enable outputs 0;
  - controlOutFwdHit=0; dataOutFwd=0.
- Push:
  - occurs when controlInValid && controlOutReady on the rising edge;
  - stores result, flags, setFlags, writeEn and destReg at the tail.
- Pop:
  - occurs when controlOutValid && controlInReady;
  - the head retires; if its setFlags=1, the flag register loads its Z/C/V/N on that edge.
- Handshake timing:
  - controlOutReady = (count < DEPTH), decoded from registered count only; there is no combinational path from controlInReady.
  - controlOutValid = (count != 0).
  - Head outputs come straight from storage; no bubble.
- Latency: an entry pushed at edge N is presented at the head in cycle N+1 if the buffer was empty.
- Simultaneous push and pop: both take effect; count is unchanged; pointers advance modulo DEPTH.
- Full: controlOutReady=0; a controlInValid offered while full is ignored, and the sender must hold it.
- Empty: a pop is impossible since controlOutValid=0; controlInReady is don't-care.
- Flush:
  - a pop in the same cycle still completes, including its flag commit; the retiring entry is older than the flush cause;
  - all other entries are discarded and any same-cycle push is dropped;
  - count=0 next cycle; discarded entries never touch the flags.
- Flags never change except on a pop with setFlags=1. Entries with writeEn=0 still flow through, e.g. compare operations.
- Forwarding (combinational from state):
  - searches valid entries with writeEn=1 and destReg==controlInFwdReg;
  - the youngest match wins;
  - a same-cycle incoming push is not searched.
- Pointer wrap: head and tail are log2(DEPTH)-bit and wrap naturally. Count is a separate log2(DEPTH)+1-bit register.
- Reset asserted mid-operation: all entries are lost immediately and flags clear, even while controlOutValid=1.

Decomposition:
- Shared package (also used by the alu and writeback stages):
  - DATA_W and REG_W constants;
  - flag bit positions Z=3, C=2, V=1, N=0;
  - packed entry typedef {result, flags[3:0], setFlags, writeEn, destReg}.
- One natural sub-module: result_fifo, a generic DEPTH-entry in-order FIFO with flush, exposing all entries for the forwarding search.
- The flag register and forwarding mux stay in the top module.

Test Plan:
- Reset then single push: result=0x00_0000_0005, flags 0100, setFlags=1, dest=3, controlInReady=1 -> controlOutValid high the next cycle with data 5 and dest 3; after the pop edge, C=1 and Z/V/N=0.
- Backpressure: controlInReady=0, push three entries -> controlOutReady=0 after the second; the third is held; release -> outputs emerge in order with no loss or duplication.
- Simultaneous push/pop at count=1 for 10 cycles -> count stays 1, every entry appears exactly once, pointers wrap.
- Flush with a head pop in the same cycle: head has setFlags=1 and Z=1; second entry has N=1 -> Z=1, N=0 afterward; controlOutValid=0 the next cycle; a same-cycle push is dropped.
- Forwarding: entries dest=7 data=0xA (older) and dest=7 data=0xB (younger), controlInFwdReg=7 -> hit with data 0xB; when the younger has writeEn=0 -> data 0xA; controlInFwdReg=8 -> hit=0, data 0.
- Assert rst_n low asynchronously between edges with 2 entries held -> outputs, flags and ready return to reset values immediately.
